// File: rtl/fpu_pkg.sv
// Shared constants for the FPU result stage: op codes, class bit positions,
// IEEE-754 single-precision field constants and the canonical quiet NaN.
// No logic lives here; the stage and the classifier import it.
package fpu_pkg;

  // ALU op codes carried alongside each result
  localparam logic [1:0] FOP_ADD = 2'b00;
  localparam logic [1:0] FOP_SUB = 2'b01;
  localparam logic [1:0] FOP_MUL = 2'b10;
  localparam logic [1:0] FOP_DIV = 2'b11;

  // Bit positions inside the 5-bit class vector {neg, nan, inf, zero, denorm}
  localparam int CLS_NEG    = 4;
  localparam int CLS_NAN    = 3;
  localparam int CLS_INF    = 2;
  localparam int CLS_ZERO   = 1;
  localparam int CLS_DENORM = 0;

  localparam int CLS_W = 5;

  // Exponent field value shared by NaN and infinity
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  // Canonical quiet NaN (positive, payload dropped)
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_classify.sv
// Classifies an IEEE-754 single into {neg, nan, inf, zero, denorm}.
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: y (32-bit pattern in), cls (5-bit class out, bit order from fpu_pkg).
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0]      y,
  output logic [CLS_W-1:0] cls
);

  logic [7:0]  exp_f;
  logic [22:0] man_f;
  logic        exp_all1;
  logic        exp_zero;
  logic        man_zero;

  assign exp_f    = y[30:23];
  assign man_f    = y[22:0];
  assign exp_all1 = (exp_f == EXP_ALL1);
  assign exp_zero = (exp_f == 8'h00);
  assign man_zero = (man_f == 23'd0);

  // Magnitude classes are mutually exclusive by construction; normal
  // numbers leave all four clear.
  always_comb begin
    cls             = '0;
    cls[CLS_NEG]    = y[31];
    cls[CLS_NAN]    = exp_all1 & ~man_zero;
    cls[CLS_INF]    = exp_all1 &  man_zero;
    cls[CLS_ZERO]   = exp_zero &  man_zero;
    cls[CLS_DENORM] = exp_zero & ~man_zero;
  end

endmodule

// File: rtl/fpu_result_stage.sv
// Registered writeback stage: captures ALU results with op/tag/class into a FIFO.
// Latency: a result pushed at edge N is presented on out_* after edge N.
// Backpressure: in_ready = not full (registered state only); a stalled consumer never drops results.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready, in_y/op/tag      ALU result input handshake
//   out_valid/out_ready, out_y/op/tag   head entry output handshake
//   out_class                           {neg, nan, inf, zero, denorm} of out_y
//   clear_sticky, sticky                sticky {nan, inf, zero, denorm} of pushed results
//   retired                             count of popped results (wraps)
// Build option: define FPU_CANON_NAN_EN to store every NaN as FP32_QNAN.
module fpu_result_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [1:0]       out_op,
  output logic [TAG_W-1:0] out_tag,
  output logic [CLS_W-1:0] out_class,
  input  logic             clear_sticky,
  output logic [3:0]       sticky,
  output logic [CNT_W-1:0] retired
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      y;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic [CLS_W-1:0] cls;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [CLS_W-1:0] raw_cls;
  entry_t           new_entry;
  entry_t           head;
  logic             push;
  logic             pop;

  // Classification happens on the push path so the stored class always
  // matches the stored bit pattern.
  fpu_classify u_classify (
    .y   (in_y),
    .cls (raw_cls)
  );

  always_comb begin
    new_entry     = '0;
    new_entry.op  = in_op;
    new_entry.tag = in_tag;
`ifdef FPU_CANON_NAN_EN
    // Sign and payload are dropped: the canonical NaN is positive.
    if (raw_cls[CLS_NAN]) begin
      new_entry.y   = FP32_QNAN;
      new_entry.cls = CLS_W'(1) << CLS_NAN;
    end else begin
      new_entry.y   = in_y;
      new_entry.cls = raw_cls;
    end
`else
    new_entry.y   = in_y;
    new_entry.cls = raw_cls;
`endif
  end

  // Both flags come from registered occupancy only, so out_ready never
  // reaches in_ready combinationally; a full FIFO refuses a push even when
  // the head is being popped in the same cycle.
  assign in_ready  = (count_q != OCC_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sticky_d  = sticky_q;
    retired_d = retired_q;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      retired_d = retired_q + CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    // A clear in the same cycle as a push keeps only the new result's flags.
    if (clear_sticky) begin
      sticky_d = push ? new_entry.cls[3:0] : 4'b0000;
    end else if (push) begin
      sticky_d = sticky_q | new_entry.cls[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sticky_q  <= '0;
      retired_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
      retired_q <= retired_d;
    end
  end

  // Outputs read as zero while the FIFO is empty.
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_y     = head.y;
  assign out_op    = head.op;
  assign out_tag   = head.tag;
  assign out_class = head.cls;
  assign sticky    = sticky_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_fpu_result_stage.sv
module tb_fpu_result_stage;
  import fpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_y;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [1:0]       out_op;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_class;
  logic             clear_sticky;
  logic [3:0]       sticky;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  fpu_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_op        (in_op),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_op       (out_op),
    .out_tag      (out_tag),
    .out_class    (out_class),
    .clear_sticky (clear_sticky),
    .sticky       (sticky),
    .retired      (retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference classification straight from the IEEE-754 field rules.
  function automatic logic [4:0] ref_class(input logic [31:0] y);
    int unsigned ex;
    int unsigned fr;
    logic [4:0]  c;
    ex = int'(y >> 23) & 255;
    fr = int'(y & 32'h007F_FFFF);
    c  = 5'b00000;
    c[4] = y[31];
    if (ex == 255 && fr != 0) c[3] = 1'b1;
    if (ex == 255 && fr == 0) c[2] = 1'b1;
    if (ex == 0 && fr == 0)   c[1] = 1'b1;
    if (ex == 0 && fr != 0)   c[0] = 1'b1;
    return c;
  endfunction

  // Value the stage is expected to store for a given input.
  function automatic logic [31:0] ref_store(input logic [31:0] y);
`ifdef FPU_CANON_NAN_EN
    if (ref_class(y) & 5'b01000) return 32'h7FC0_0000;
`endif
    return y;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      1: r[30:23] = 8'hFF;
      2: r[30:23] = 8'h00;
      3: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      4: r[30:0] = '0;
      default: ;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] y;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] exp_y;
    logic [4:0]  exp_cls;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [4:0]  cls;
  } ent_t;

  vec_t        vt [9];
  ent_t        q [$];
  ent_t        e;
  logic [3:0]  exp_st;
  int unsigned exp_ret;
  logic        do_push;
  logic        do_pop;

  initial begin
    vt[0] = '{32'h40A0_0000, FOP_ADD, 4'h3, 32'h40A0_0000, 5'b00000};
    vt[1] = '{32'h7F80_0000, FOP_SUB, 4'h5, 32'h7F80_0000, 5'b00100};
    vt[2] = '{32'h0000_0001, FOP_MUL, 4'h6, 32'h0000_0001, 5'b00001};
    vt[3] = '{32'h8000_0000, FOP_DIV, 4'h7, 32'h8000_0000, 5'b10010};
`ifdef FPU_CANON_NAN_EN
    vt[4] = '{32'hFFC0_0001, FOP_DIV, 4'h9, 32'h7FC0_0000, 5'b01000};
    vt[5] = '{32'h7F80_0001, FOP_ADD, 4'hA, 32'h7FC0_0000, 5'b01000};
`else
    vt[4] = '{32'hFFC0_0001, FOP_DIV, 4'h9, 32'hFFC0_0001, 5'b11000};
    vt[5] = '{32'h7F80_0001, FOP_ADD, 4'hA, 32'h7F80_0001, 5'b01000};
`endif
    vt[6] = '{32'hFF80_0000, FOP_MUL, 4'hB, 32'hFF80_0000, 5'b10100};
    vt[7] = '{32'h807F_FFFF, FOP_SUB, 4'hC, 32'h807F_FFFF, 5'b10001};
    vt[8] = '{32'h0000_0000, FOP_ADD, 4'hF, 32'h0000_0000, 5'b00010};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    in_y = '0; in_op = '0; in_tag = '0;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sticky",    32'(sticky),    32'd0);
    chk("rst_retired",   32'(retired),   32'd0);
    chk("rst_out_y",     out_y,          32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: push one result at a time with the consumer always ready
    exp_ret = 0;
    exp_st  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("tbl_retired", 32'(retired), exp_ret);
      in_valid = 1'b1; in_y = vt[i].y; in_op = vt[i].op; in_tag = vt[i].tag;
      @(negedge clk);
      in_valid = 1'b0;
      exp_st = exp_st | vt[i].exp_cls[3:0];
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_out_y",     out_y,          vt[i].exp_y);
      chk("tbl_out_op",    32'(out_op),    32'(vt[i].op));
      chk("tbl_out_tag",   32'(out_tag),   32'(vt[i].tag));
      chk("tbl_out_class", 32'(out_class), 32'(vt[i].exp_cls));
      chk("tbl_sticky",    32'(sticky),    32'(exp_st));
      if (i == 3) chk("tbl_sticky_0111", 32'(sticky), 32'b0111);
      exp_ret++;
    end
    @(negedge clk);
    chk("tbl_retired_end", 32'(retired), exp_ret);

    // Backpressure: three back-to-back pushes into a stalled two-entry FIFO
    out_ready = 1'b0;
    in_valid = 1'b1; in_y = 32'h3F80_0000; in_op = FOP_ADD; in_tag = 4'h1;
    @(negedge clk);
    chk("bp_ready_after_1", 32'(in_ready), 32'd1);
    in_y = 32'hC000_0000; in_op = FOP_MUL; in_tag = 4'h2;
    @(negedge clk);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    in_y = 32'h4040_0000; in_op = FOP_DIV; in_tag = 4'h3;
    @(negedge clk);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_head_a",     out_y,         32'h3F80_0000);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_b",     out_y,         32'hC000_0000);
    chk("bp_head_b_tag", 32'(out_tag),  32'd2);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_drained",    32'(out_valid), 32'd0);
    chk("bp_empty_y",    out_y,          32'd0);
    exp_ret += 2;
    chk("bp_retired",    32'(retired),   exp_ret);

    // clear_sticky together with a push, then alone
    in_valid = 1'b1; in_y = 32'h0000_0000; in_op = FOP_SUB; in_tag = 4'h4; clear_sticky = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr_push_sticky", 32'(sticky),    32'b0010);
    chk("clr_push_class",  32'(out_class), 32'b00010);
    @(negedge clk);
    clear_sticky = 1'b0;
    exp_ret++;
    chk("clr_alone_sticky", 32'(sticky),  32'd0);
    chk("clr_retired",      32'(retired), exp_ret);

    // Randomized traffic against the queue model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_st = 4'b0000;
    exp_ret = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
      if (q.size() != 0) begin
        chk("rnd_out_y",     out_y,          q[0].y);
        chk("rnd_out_op",    32'(out_op),    32'(q[0].op));
        chk("rnd_out_tag",   32'(out_tag),   32'(q[0].tag));
        chk("rnd_out_class", 32'(out_class), 32'(q[0].cls));
      end else begin
        chk("rnd_empty_y",     out_y,          32'd0);
        chk("rnd_empty_class", 32'(out_class), 32'd0);
      end
      chk("rnd_sticky",  32'(sticky),  32'(exp_st));
      chk("rnd_retired", 32'(retired), exp_ret & 32'hFFFF);

      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clear_sticky = ($urandom_range(0, 15) == 0);
      in_y         = rand_fp();
      in_op        = 2'($urandom_range(0, 3));
      in_tag       = 4'($urandom_range(0, 15));

      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      e.y   = ref_store(in_y);
      e.op  = in_op;
      e.tag = in_tag;
      e.cls = ref_class(e.y);
      if (do_pop) begin
        void'(q.pop_front());
        exp_ret++;
      end
      if (do_push) q.push_back(e);
      if (clear_sticky) exp_st = do_push ? e.cls[3:0] : 4'b0000;
      else if (do_push) exp_st = exp_st | e.cls[3:0];
      @(negedge clk);
    end
    in_valid = 1'b0; clear_sticky = 1'b0;

    // Asynchronous reset with one entry queued
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_y = 32'h4040_0000; in_op = FOP_ADD; in_tag = 4'h8;
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_retired",   32'(retired),   32'd0);
    chk("arst_sticky",    32'(sticky),    32'd0);
    chk("arst_out_y",     out_y,          32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_result_stage.md
Name: fpu_result_stage

Overview:
- Registered writeback stage directly downstream of the combinational single-precision ALU (add/sub/mul/div, 2-bit op).
- Captures each ALU result with its op code and a tag, and classifies the IEEE-754 pattern (NaN/Inf/zero/denormal/sign).
- Buffers results in a small FIFO with valid/ready on both sides, so a stalled consumer never drops a result.
- Maintains sticky exception flags and a retired-result counter for software/bench inspection.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- TAG_W, 4, width of the caller tag carried with each result.
- CNT_W, 16, width of the retired-result counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  stage can accept; equals not full.
- in_y  in  32  ALU result, IEEE-754 single.
- in_op  in  2  op that produced it: 00 add, 01 sub, 10 mul, 11 div.
- in_tag  in  TAG_W  caller tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_y  out  32  head result.
- out_op  out  2  head op.
- out_tag  out  TAG_W  head tag.
- out_class  out  5  {neg, nan, inf, zero, denorm} of out_y.
- clear_sticky  in  1  clears sticky flags.
- sticky  out  4  {nan, inf, zero, denorm}, OR of all pushed results since last clear/reset.
- retired  out  CNT_W  count of popped results.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, read/write pointers 0, out_valid=0, in_ready=1, sticky=0, retired=0. out_y, out_op, out_tag, out_class read 0 while empty.
- Push: in_valid && in_ready at an edge writes {in_y, in_op, in_tag, class(in_y)} at the write pointer. The pointer wraps modulo DEPTH.
- Pop: out_valid && out_ready at an edge advances the read pointer, wrapping modulo DEPTH.
- Latency: a result pushed at edge N drives out_valid=1 after edge N. It is not visible combinationally in the same cycle.
- Occupancy count is 0..DEPTH.
  - in_ready = (count != DEPTH). It is registered-state only; there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- When full, a push cannot occur even if a pop happens that cycle.
- Empty with out_ready=1: no effect.
- Classification, with e = y[30:23] and m = y[22:0]:
  - nan = (e==FF && m!=0)
  - inf = (e==FF && m==0)
  - zero = (e==0 && m==0)
  - denorm = (e==0 && m!=0)
  - neg = y[31]
  - The four magnitude classes are mutually exclusive.
- Sticky update:
  - On a push, sticky <= sticky | class[3:0].
  - clear_sticky alone: sticky <= 0.
  - clear_sticky together with a push: sticky <= class[3:0] of the pushed result.
- retired increments by 1 on every pop and wraps from all-ones to 0.
- Asserting rst_n=0 mid-stream discards all queued entries immediately.

Optional Feature:
- FPU_CANON_NAN_EN defined: any NaN is stored as canonical 32'h7FC00000, so sign and payload are dropped. out_class.neg=0 for NaN; out_class.nan=1.
- Undefined: the NaN bit pattern passes unmodified and neg reflects bit 31.

Decomposition:
- Package fpu_pkg holds:
  - op code constants FOP_ADD/SUB/MUL/DIV;
  - class bit indices CLS_NEG/NAN/INF/ZERO/DENORM;
  - EXP_ALL1 = 8'hFF;
  - canonical NaN constant FP32_QNAN = 32'h7FC00000.
- One combinational sub-module, fpu_classify (32-bit in, 5-bit class out), instantiated on the push path.

Test Plan:
- Reset, then push in_y=40A00000 (5.0), op=00, tag=3, with out_ready=1 -> out_valid=1 next cycle, out_y=40A00000, out_tag=3, out_class=00000; retired=1 after the pop edge.
- out_ready=0, push 3 results back-to-back -> first two accepted, in_ready=0 on the third; release out_ready -> results popped in order, no loss, no duplication.
- Push 7F800000, then 00000001, then 80000000 -> out_class 00100, 00001, 10010 respectively; sticky=0111.
- Push FFC00001 -> with FPU_CANON_NAN_EN: out_y=7FC00000, class=01000; without: out_y=FFC00001, class=11000; sticky nan bit=1 in both.
- clear_sticky asserted in the same cycle as a push of 00000000 -> sticky=0010; clear_sticky alone next cycle -> sticky=0000.
- With count=1, drop rst_n mid-cycle -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; retired=0.
